noc_packet_sender: RTL and testbench

Packet-to-flit transmitter that drives the sending end of a `Noc_flit_interface` into a router input FIFO on one selected virtual channel. It accepts a packet descriptor (destination, VC, payload length) and a payload word stream. It then emits a head flit, body flits and a tail flit with wormhole semantics. It sits in the local network interface, between a core/DMA master and the router's LOCAL port.

---
 rtl/noc_packet_sender_pkg.sv | 23 ++
 rtl/noc_packet_sender_if.sv | 33 +++
 rtl/noc_packet_sender_out_reg.sv | 53 +++++
 rtl/noc_packet_sender.sv | 148 ++++++++++++++
 tb/tb_noc_packet_sender.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_packet_sender_pkg.sv
// Shared NoC parameters and types for the packet sender: flit layout and
// sender FSM encoding.
package Noc_parameters;

    localparam int Noc_VC_Channel = 2;
    localparam int Noc_Data_Width = 32;
    localparam int Noc_Dest_Width = 8;
    localparam int Noc_Len_Width  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } sender_state_e;

    // Flit layout: head flag in the MSB, tail flag below it, payload in the rest.
    typedef struct packed {
        logic                      head;
        logic                      tail;
        logic [Noc_Data_Width-3:0] data;
    } noc_flit_t;

endpackage

// File: rtl/noc_packet_sender_if.sv
// Flit link between a sender and one router input port, with one valid/ready
// pair and one almost-full indication per virtual channel.
interface Noc_flit_interface
    import Noc_parameters::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int FLIT_WIDTH = Noc_Data_Width
);

    // Handshake: a flit moves on VC v in any cycle where valid[v] and ready[v]
    // are both high at the rising clock edge. Once valid[v] rises, valid and
    // flit stay stable until that transfer; ready may change freely. vc_ready[v]
    // reports that VC v's FIFO is below its almost-full threshold.
    logic [CHANNELS-1:0]   valid;
    logic [CHANNELS-1:0]   ready;
    logic [CHANNELS-1:0]   vc_ready;
    logic [FLIT_WIDTH-1:0] flit [1];

    modport sender (
        output valid,
        output flit,
        input  ready,
        input  vc_ready
    );

    modport receiver (
        input  valid,
        input  flit,
        output ready,
        output vc_ready
    );

endinterface

// File: rtl/noc_packet_sender_out_reg.sv
// Single-entry flit output register. A flit loaded while the register is empty
// is presented in the same cycle and only stored if it is not taken at once.
module noc_flit_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] flit_i,
    input  logic             accept_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] flit_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] flit_q, flit_d;

    assign valid_o = full_q | load_i;
    assign full_o  = full_q;
    assign flit_o  = full_q ? flit_q : (load_i ? flit_i : '0);

    // The caller only loads when the register is empty or draining this cycle.
    always_comb begin
        full_d = full_q;
        flit_d = flit_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (full_q) begin
            if (accept_i) begin
                full_d = load_i;
                if (load_i) begin
                    flit_d = flit_i;
                end
            end
        end else if (load_i && !accept_i) begin
            full_d = 1'b1;
            flit_d = flit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            flit_q <= '0;
        end else begin
            full_q <= full_d;
            flit_q <= flit_d;
        end
    end

endmodule

// File: rtl/noc_packet_sender.sv
// Packet-to-flit transmitter: turns a descriptor plus payload stream into a
// head/body/tail wormhole packet on one virtual channel of a router port.
module noc_packet_sender
    import Noc_parameters::*;
#(
    parameter int  CHANNELS   = Noc_VC_Channel,
    parameter int  FLIT_WIDTH = Noc_Data_Width,
    parameter int  DEST_WIDTH = Noc_Dest_Width,
    parameter int  LEN_WIDTH  = Noc_Len_Width,
    localparam int VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW         = FLIT_WIDTH - 2
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  i_clear,
    input  logic                  i_pkt_valid,
    output logic                  o_pkt_ready,
    input  logic [DEST_WIDTH-1:0] i_pkt_dest,
    input  logic [VC_W-1:0]       i_pkt_vc,
    input  logic [LEN_WIDTH-1:0]  i_pkt_len,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic [PW-1:0]         i_data,
    Noc_flit_interface.sender     sender_if,
    output logic                  o_busy,
    output logic [15:0]           o_pkt_count,
    output sender_state_e         o_state
);

    sender_state_e         state_q, state_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [VC_W-1:0]       vc_q, vc_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [15:0]           pkt_count_q, pkt_count_d;

    logic [VC_W-1:0]       pkt_vc_sel;
    logic [PW-1:0]         head_payload;
    logic [FLIT_WIDTH-1:0] head_flit, body_flit, load_flit, out_flit;
    logic                  head_load, body_load, load;
    logic                  out_valid, out_full, out_ready, out_vc_ready;
    logic                  out_xfer, out_tail;

    // Out-of-range VC numbers fold onto VC 0.
    assign pkt_vc_sel   = (int'(i_pkt_vc) < CHANNELS) ? i_pkt_vc : '0;

    assign head_payload = PW'({len_q, dest_q});
    assign head_flit    = {1'b1, (len_q == '0), head_payload};
    assign body_flit    = {1'b0, (rem_q == LEN_WIDTH'(1)), i_data};

    assign out_ready    = sender_if.ready[vc_q];
    assign out_vc_ready = sender_if.vc_ready[vc_q];
    assign out_xfer     = out_valid & out_ready;
    assign out_tail     = out_flit[FLIT_WIDTH-2];

    // vc_ready gates only the head; body flits hold the VC and follow ready.
    assign head_load    = (state_q == ST_HEAD) && !out_full && out_vc_ready && !i_clear;
    assign o_data_ready = (state_q == ST_BODY) && (rem_q != '0) &&
                          (!out_full || out_ready) && !i_clear;
    assign body_load    = o_data_ready && i_data_valid;
    assign load         = head_load | body_load;
    assign load_flit    = head_load ? head_flit : body_flit;

    assign o_pkt_ready  = (state_q == ST_IDLE) && !i_clear;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_pkt_count  = pkt_count_q;
    assign o_state      = state_q;

    assign sender_if.valid   = {CHANNELS{out_valid}} & (CHANNELS'(1) << vc_q);
    assign sender_if.flit[0] = out_flit;

    noc_flit_out_reg #(
        .WIDTH (FLIT_WIDTH)
    ) u_out_reg (
        .clk_i    (noc_clk),
        .rst_ni   (noc_rst_n),
        .clear_i  (i_clear),
        .load_i   (load),
        .flit_i   (load_flit),
        .accept_i (out_ready),
        .valid_o  (out_valid),
        .full_o   (out_full),
        .flit_o   (out_flit)
    );

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        vc_d        = vc_q;
        len_d       = len_q;
        rem_d       = rem_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_IDLE: begin
                if (i_pkt_valid && o_pkt_ready) begin
                    dest_d  = i_pkt_dest;
                    vc_d    = pkt_vc_sel;
                    len_d   = i_pkt_len;
                    rem_d   = i_pkt_len;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (out_xfer) begin
                    state_d = (len_q == '0) ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                if (body_load) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                end
                if (out_xfer && out_tail) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (out_xfer && out_tail && !i_clear) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end

        // Abort wins over every handshake seen in the same cycle.
        if (i_clear) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= ST_IDLE;
            dest_q      <= '0;
            vc_q        <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            vc_q        <= vc_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_noc_packet_sender.sv
// Directed bench for noc_packet_sender on a 3-VC, 32-bit link: flit scoreboard
// plus hand-computed checks of latency, backpressure, gating, clear and wrap.
module tb_noc_packet_sender;
    import Noc_parameters::*;

    localparam int CH = 3;
    localparam int FW = 32;
    localparam int PW = FW - 2;
    localparam int VW = 2;

    logic           noc_clk = 1'b0;
    logic           noc_rst_n = 1'b0;
    logic           i_clear = 1'b0;
    logic           i_pkt_valid = 1'b0;
    logic           o_pkt_ready;
    logic [7:0]     i_pkt_dest = '0;
    logic [VW-1:0]  i_pkt_vc = '0;
    logic [7:0]     i_pkt_len = '0;
    logic           i_data_valid;
    logic           o_data_ready;
    logic [PW-1:0]  i_data;
    logic           o_busy;
    logic [15:0]    o_pkt_count;
    sender_state_e  o_state;

    logic [FW-1:0]  exp_q [$];
    logic [CH-1:0]  expv_q [$];
    logic [PW-1:0]  data_src_q [$];
    logic [PW-1:0]  pend_q [$];
    logic [15:0]    exp_count = '0;
    int             n_checks = 0;
    int             n_fail = 0;

    always #5 noc_clk = ~noc_clk;

    Noc_flit_interface #(.CHANNELS(CH), .FLIT_WIDTH(FW)) nif ();

    noc_packet_sender #(
        .CHANNELS   (CH),
        .FLIT_WIDTH (FW),
        .DEST_WIDTH (8),
        .LEN_WIDTH  (8)
    ) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .i_clear      (i_clear),
        .i_pkt_valid  (i_pkt_valid),
        .o_pkt_ready  (o_pkt_ready),
        .i_pkt_dest   (i_pkt_dest),
        .i_pkt_vc     (i_pkt_vc),
        .i_pkt_len    (i_pkt_len),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_data       (i_data),
        .sender_if    (nif),
        .o_busy       (o_busy),
        .o_pkt_count  (o_pkt_count),
        .o_state      (o_state)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk_head(input logic [7:0] dest, input logic [7:0] len);
        logic [PW-1:0] p;
        p = '0;
        p[15:0] = {len, dest};
        return {1'b1, (len == 8'd0), p};
    endfunction

    function automatic logic [CH-1:0] vc_onehot(input logic [VW-1:0] vc);
        logic [CH-1:0] o;
        o = '0;
        if (int'(vc) < CH) o[vc] = 1'b1;
        else o[0] = 1'b1;
        return o;
    endfunction

    task automatic add_word(input logic [PW-1:0] w);
        data_src_q.push_back(w);
        pend_q.push_back(w);
    endtask

    // Queues expectations, then performs the descriptor handshake; returns at
    // the falling edge inside the first HEAD cycle.
    task automatic send_pkt(input logic [7:0] dest, input logic [VW-1:0] vc, input logic [7:0] len);
        int n;
        exp_q.push_back(mk_head(dest, len));
        expv_q.push_back(vc_onehot(vc));
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({1'b0, (i == int'(len) - 1), pend_q.pop_front()});
            expv_q.push_back(vc_onehot(vc));
        end
        @(negedge noc_clk);
        i_pkt_valid = 1'b1;
        i_pkt_dest  = dest;
        i_pkt_vc    = vc;
        i_pkt_len   = len;
        #2;
        n = 0;
        while (!o_pkt_ready && n < 40) begin
            @(negedge noc_clk);
            #2;
            n++;
        end
        if (n >= 40) check_eq("desc_wait", 64'(o_pkt_ready), 64'd1);
        @(negedge noc_clk);
        i_pkt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge noc_clk);
            #3;
            n++;
        end while ((o_busy || exp_q.size() != 0) && n < 60);
        check_eq("idle_reached", 64'(o_busy), 64'd0);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic flush_all();
        exp_q.delete();
        expv_q.delete();
        data_src_q.delete();
        pend_q.delete();
    endtask

    initial begin
        i_data_valid = 1'b0;
        i_data       = '0;
        forever begin
            @(negedge noc_clk);
            if (data_src_q.size() > 0) begin
                i_data_valid = 1'b1;
                i_data       = data_src_q[0];
            end else begin
                i_data_valid = 1'b0;
                i_data       = '0;
            end
            #2;
            if (i_data_valid && o_data_ready) void'(data_src_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(negedge noc_clk);
            #2;
            if (noc_rst_n && |(nif.valid & nif.ready)) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexp_flit", 64'(nif.valid), 64'd0);
                end else begin
                    check_eq("flit", 64'(nif.flit[0]), 64'(exp_q.pop_front()));
                    check_eq("valid_vec", 64'(nif.valid), 64'(expv_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        nif.ready    = '1;
        nif.vc_ready = '1;

        // Reset state
        repeat (2) @(negedge noc_clk);
        #2;
        check_eq("rst_pkt_ready", 64'(o_pkt_ready), 64'd1);
        check_eq("rst_data_ready", 64'(o_data_ready), 64'd0);
        check_eq("rst_valid", 64'(nif.valid), 64'd0);
        check_eq("rst_flit", 64'(nif.flit[0]), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_count", 64'(o_pkt_count), 64'd0);
        check_eq("rst_state", 64'(o_state), 64'(ST_IDLE));
        @(negedge noc_clk);
        noc_rst_n = 1'b1;

        // Single-flit packet, head valid in the cycle after the descriptor
        send_pkt(8'h12, 2'd1, 8'd0);
        #2;
        check_eq("t1_head_valid", 64'(nif.valid), 64'h2);
        check_eq("t1_head_flit", 64'(nif.flit[0]), 64'hC000_0012);
        wait_idle();
        exp_count++;
        check_eq("t1_count", 64'(o_pkt_count), 64'd1);

        // Full throughput: head, A, B, C(tail) on consecutive cycles
        add_word(30'h0A0A);
        add_word(30'h0B0B);
        add_word(30'h0C0C);
        send_pkt(8'h34, 2'd2, 8'd3);
        #2;
        check_eq("t2_b2b_head", 64'(|(nif.valid & nif.ready)), 64'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge noc_clk);
            #2;
            check_eq($sformatf("t2_b2b_%0d", k), 64'(|(nif.valid & nif.ready)), 64'd1);
        end
        check_eq("t2_tail_c", 64'(nif.flit[0]), 64'h4000_0C0C);
        @(negedge noc_clk);
        #2;
        check_eq("t2_busy_fall", 64'(o_busy), 64'd0);
        wait_idle();
        exp_count++;
        check_eq("t2_count", 64'(o_pkt_count), 64'(exp_count));

        // Backpressure: ready[2] low for three cycles while the second body flit waits
        add_word(30'h0D0D);
        add_word(30'h0E0E);
        add_word(30'h0F0F);
        send_pkt(8'h34, 2'd2, 8'd3);
        @(negedge noc_clk);
        @(negedge noc_clk);
        nif.ready[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge noc_clk);
            #2;
            check_eq("t3_data_ready_low", 64'(o_data_ready), 64'd0);
            check_eq("t3_held_flit", 64'(nif.flit[0]), 64'h0000_0E0E);
            check_eq("t3_held_valid", 64'(nif.valid), 64'h4);
        end
        @(negedge noc_clk);
        nif.ready[2] = 1'b1;
        wait_idle();
        exp_count++;
        check_eq("t3_count", 64'(o_pkt_count), 64'(exp_count));

        // Head gating on vc_ready[0]; other VCs' vc_ready is ignored
        nif.vc_ready = 3'b110;
        add_word(30'h1111);
        send_pkt(8'h56, 2'd0, 8'd1);
        for (int k = 0; k < 5; k++) begin
            #2;
            check_eq("t4_gated_valid", 64'(nif.valid), 64'd0);
            @(negedge noc_clk);
        end
        nif.vc_ready[0] = 1'b1;
        #2;
        check_eq("t4_head_valid", 64'(nif.valid), 64'h1);
        check_eq("t4_head_flit", 64'(nif.flit[0]), 64'h8000_0156);
        wait_idle();
        exp_count++;
        check_eq("t4_count", 64'(o_pkt_count), 64'(exp_count));

        // Out-of-range VC folds onto VC 0
        send_pkt(8'h77, 2'd3, 8'd0);
        #2;
        check_eq("t4b_vc_fold", 64'(nif.valid), 64'h1);
        wait_idle();
        exp_count++;
        check_eq("t4b_count", 64'(o_pkt_count), 64'(exp_count));

        // Clear with a body flit stuck in the output register
        add_word(30'h2001);
        add_word(30'h2002);
        add_word(30'h2003);
        add_word(30'h2004);
        send_pkt(8'h9A, 2'd1, 8'd4);
        @(negedge noc_clk);
        @(negedge noc_clk);
        nif.ready[1] = 1'b0;
        @(negedge noc_clk);
        i_clear = 1'b1;
        @(negedge noc_clk);
        i_clear = 1'b0;
        #2;
        check_eq("t5_valid", 64'(nif.valid), 64'd0);
        check_eq("t5_state", 64'(o_state), 64'(ST_IDLE));
        check_eq("t5_pkt_ready", 64'(o_pkt_ready), 64'd1);
        check_eq("t5_data_ready", 64'(o_data_ready), 64'd0);
        check_eq("t5_count", 64'(o_pkt_count), 64'(exp_count));
        #1;
        flush_all();
        nif.ready[1] = 1'b1;
        send_pkt(8'h01, 2'd1, 8'd0);
        wait_idle();
        exp_count++;
        check_eq("t5_recover_count", 64'(o_pkt_count), 64'(exp_count));

        // Counter wrap from a preloaded value
        @(negedge noc_clk);
        force dut.pkt_count_q = 16'hFFFE;
        @(negedge noc_clk);
        release dut.pkt_count_q;
        exp_count = 16'hFFFE;
        send_pkt(8'h02, 2'd0, 8'd0);
        wait_idle();
        exp_count++;
        check_eq("t6_count_ffff", 64'(o_pkt_count), 64'hFFFF);
        send_pkt(8'h03, 2'd0, 8'd0);
        wait_idle();
        exp_count++;
        check_eq("t6_wrap", 64'(o_pkt_count), 64'(exp_count));
        check_eq("t6_wrap_zero", 64'(o_pkt_count), 64'h0);

        // Asynchronous reset mid-packet
        nif.ready[2] = 1'b0;
        add_word(30'h3001);
        add_word(30'h3002);
        add_word(30'h3003);
        send_pkt(8'h44, 2'd2, 8'd3);
        #2;
        check_eq("t7_head_held", 64'(nif.valid), 64'h4);
        #1;
        noc_rst_n = 1'b0;
        #1;
        check_eq("t7_valid", 64'(nif.valid), 64'd0);
        check_eq("t7_flit", 64'(nif.flit[0]), 64'd0);
        check_eq("t7_busy", 64'(o_busy), 64'd0);
        check_eq("t7_pkt_ready", 64'(o_pkt_ready), 64'd1);
        check_eq("t7_count", 64'(o_pkt_count), 64'd0);
        flush_all();
        nif.ready = '1;
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        repeat (2) @(negedge noc_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
